// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC owner, single-outstanding imem fetcher, prefetch FIFO.
// Optional performance counters are enabled with `define FETCH_PERF_COUNT_EN.
// Redirects flush the FIFO and discard any in-flight memory response.

// Purpose: small generic FIFO with synchronous flush and zeroed head when empty.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: head held until pop_rdy; a push into a full FIFO is dropped unless a pop frees a slot.
module ifu_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push_vld,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop_rdy,
    output logic                   head_vld,
    output logic [WIDTH-1:0]       head_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign head_vld = (count != '0);
    assign head_dat = head_vld ? mem[rd_ptr] : '0;
    assign do_pop   = pop_rdy && head_vld;
    assign do_push  = push_vld && ((count != FULL) || do_pop);

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care while the slot is not occupied.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_dat;
    end
endmodule

// Purpose: owns the PC, fetches words over req/gnt/rvalid and queues them for DataPath.
// Latency: rvalid in cycle M shows on inst_valid in M+1 when the FIFO was empty.
// Backpressure: inst_ready low fills the FIFO; no new request issues once it would be full or halt is high.
module instr_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              initiate,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       stall_count
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL = FIFO_DEPTH[CNT_W-1:0];

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              discard;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  cnt_next;
    logic              push_vld;
    logic              inst_pop;
    logic              issue_ok;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] redir_tgt;
    logic              unused_redir_lsb;

    assign unused_redir_lsb = ^redirect_pc[1:0];
    assign redir_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign pc_plus4  = pc + ADDR_W'(4);
    assign inst_pop  = inst_valid && inst_ready;
    // A response that races a redirect is never written into the FIFO.
    assign push_vld  = (state == WAIT) && imem_rvalid && !redirect_valid;
    // Occupancy after this cycle's push/pop decides whether another word may be requested,
    // so the single outstanding response always has a free slot.
    assign cnt_next  = fifo_count + CNT_W'(push_vld) - CNT_W'(inst_pop);
    assign issue_ok  = !halt && (cnt_next < FULL);

    ifu_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (initiate),
        .flush    (redirect_valid),
        .push_vld (push_vld),
        .push_dat ({pc, imem_rdata}),
        .pop_rdy  (inst_ready),
        .head_vld (inst_valid),
        .head_dat ({inst_pc, inst_data}),
        .count    (fifo_count)
    );

    // Fetch FSM: issues requests, tracks the outstanding one and drops stale responses.
    always_ff @(posedge clk or negedge initiate) begin
        if (!initiate) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            discard   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        pc <= redir_tgt;
                        if (!halt) begin
                            state     <= REQ;
                            imem_req  <= 1'b1;
                            imem_addr <= redir_tgt;
                        end
                    end else if (issue_ok) begin
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                end
                REQ: begin
                    // The address must stay put until granted, so a redirect only marks the
                    // request as stale and its response is thrown away later.
                    if (redirect_valid) begin
                        pc      <= redir_tgt;
                        discard <= 1'b1;
                    end
                    if (imem_gnt) begin
                        imem_req <= 1'b0;
                        state    <= (discard || redirect_valid) ? DROP : WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        pc <= redir_tgt;
                        if (imem_rvalid) begin
                            state <= IDLE;
                        end else begin
                            state   <= DROP;
                            discard <= 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        pc <= pc_plus4;
                        if (issue_ok) begin
                            state     <= REQ;
                            imem_req  <= 1'b1;
                            imem_addr <= pc_plus4;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (redirect_valid) pc <= redir_tgt;
                    if (imem_rvalid) begin
                        discard <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    // Free-running performance counters: delivered instructions and starved cycles.
    always_ff @(posedge clk or negedge initiate) begin
        if (!initiate) begin
            fetch_count <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (inst_pop)             fetch_count <= fetch_count + 32'd1;
            if (!inst_valid && !halt) stall_count <= stall_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory model, instruction-stream reference model, scoreboard monitor.
module tb_instr_fetch_unit;
    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        initiate, imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid, halt, inst_valid, inst_ready;
    logic [31:0] redirect_pc, inst_data, inst_pc;
`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] fetch_count, stall_count;
`endif

    int checks = 0;
    int errors = 0;
    int pops = 0;
    int pops_rst = 0;
    int gnt_total = 0;
    logic [31:0] last_gnt_addr = 32'd0;
    int gnt_delay = 0;
    int lat = 0;
    int req_cyc = 0;
    bit resp_pend = 1'b0;
    logic [31:0] resp_addr = 32'd0;
    int lat_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] next_exp = 32'd0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk            (clk),
        .initiate       (initiate),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
`ifdef FETCH_PERF_COUNT_EN
        ,
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        initiate = 1'b0;
        cyc(1);
        initiate = 1'b1;
    endtask

    task automatic wait_pops(input int target, input string nm);
        int b = 0;
        while (pops < target && b < 300) begin cyc(1); b++; end
        check(nm, 32'(pops >= target), 32'd1);
    endtask

    task automatic wait_new_gnt(input string nm);
        int g = gnt_total;
        int b = 0;
        while (gnt_total == g && b < 100) begin cyc(1); b++; end
        check(nm, 32'(gnt_total != g), 32'd1);
    endtask

    task automatic wait_gnt_addr(input logic [31:0] a, input string nm);
        int g = gnt_total;
        int b = 0;
        bit hit = 1'b0;
        while (!hit && b < 100) begin
            cyc(1); b++;
            if (gnt_total != g) begin
                g = gnt_total;
                if (last_gnt_addr == a) hit = 1'b1;
            end
        end
        check(nm, 32'(hit), 32'd1);
    endtask

    // Instruction memory: grants after gnt_delay cycles of request, answers lat cycles after gnt.
    initial begin
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            if (resp_pend) begin
                if (lat_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = resp_addr ^ KEY;
                    resp_pend   = 1'b0;
                end else lat_cnt--;
            end
            imem_gnt = 1'b0;
            if (imem_req && !resp_pend) begin
                if (req_cyc >= gnt_delay) begin
                    imem_gnt = 1'b1;
                    resp_pend = 1'b1;
                    resp_addr = imem_addr;
                    lat_cnt = lat;
                    req_cyc = 0;
                    gnt_total++;
                    last_gnt_addr = imem_addr;
                end else req_cyc++;
            end else if (!imem_req) req_cyc = 0;
        end
    end

    // Reference model: the delivered stream is consecutive words from the last reset/redirect target.
    initial begin
        forever begin
            @(posedge clk);
            if (!initiate) begin
                exp_q.delete();
                next_exp = 32'd0;
            end else if (redirect_valid) begin
                exp_q.delete();
                next_exp = redirect_pc & ~32'h3;
            end
            while (exp_q.size() < 8) begin
                exp_q.push_back(next_exp);
                next_exp = next_exp + 32'd4;
            end
        end
    end

    // Monitor: scoreboard on every consumed instruction plus request-hold legality.
    initial begin
        logic [31:0] e;
        logic        p_hold;
        logic [31:0] p_addr;
        p_hold = 1'b0; p_addr = 32'd0;
        forever begin
            @(negedge clk); #1;
            if (!initiate) begin
                pops_rst = 0;
                p_hold = 1'b0;
            end else begin
                if (p_hold) begin
                    check("req_held", {31'd0, imem_req}, 32'd1);
                    check("addr_held", imem_addr, p_addr);
                end
                if (imem_req) check("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
                if (inst_valid && inst_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_pop: got pc %h, required no instruction", inst_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("inst_pc", inst_pc, e);
                        check("inst_data", inst_data, e ^ KEY);
                    end
                    pops++;
                    pops_rst++;
                end
                p_hold = imem_req && !imem_gnt;
                p_addr = imem_addr;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        int g0;
        int b;
        int p0;
        initiate = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        halt = 1'b0; inst_ready = 1'b0;

        // Reset values
        cyc(2);
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst_data", inst_data, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);

        // Streaming from RESET_PC
        initiate = 1'b1; inst_ready = 1'b1;
        wait_pops(pops + 4, "stream_0_to_c");

        // Backpressure fills exactly FIFO_DEPTH entries, then resumes at 0x10
        inst_ready = 1'b0;
        do_reset();
        g0 = gnt_total;
        cyc(20);
        check("fill_grants", 32'(gnt_total - g0), 32'd4);
        check("fill_req_idle", {31'd0, imem_req}, 32'd0);
        check("fill_valid", {31'd0, inst_valid}, 32'd1);
        inst_ready = 1'b1;
        wait_new_gnt("resume_gnt");
        check("resume_addr", last_gnt_addr, 32'h10);
        wait_pops(pops + 5, "drain_fill");

        // Redirect while waiting on the response for 0x8
        lat = 2;
        do_reset();
        wait_gnt_addr(32'h8, "gnt_addr_8");
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        cyc(1);
        redirect_valid = 1'b0;
        check("redir_flush", {31'd0, inst_valid}, 32'd0);
        wait_new_gnt("redir_gnt");
        check("redir_addr", last_gnt_addr, 32'h100);
        wait_pops(pops + 2, "redir_stream");

        // Redirect while a request is stalled waiting for gnt
        lat = 0; gnt_delay = 3;
        b = 0;
        while (!(imem_req && req_cyc == 0 && !resp_pend) && b < 100) begin cyc(1); b++; end
        check("fresh_req", {31'd0, imem_req}, 32'd1);
        a = imem_addr;
        g0 = gnt_total;
        redirect_valid = 1'b1; redirect_pc = 32'h2000_0010;
        cyc(1);
        redirect_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (gnt_total != g0) break;
            check("stall_req", {31'd0, imem_req}, 32'd1);
            check("stall_addr", imem_addr, a);
            cyc(1);
        end
        check("stale_gnt_addr", last_gnt_addr, a);
        gnt_delay = 0;
        wait_new_gnt("redir2_gnt");
        check("redir2_addr", last_gnt_addr, 32'h2000_0010);
        wait_pops(pops + 2, "redir2_stream");

        // Address wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc(1);
        redirect_valid = 1'b0;
        wait_gnt_addr(32'hFFFF_FFFC, "gnt_top");
        wait_new_gnt("wrap_gnt");
        check("wrap_addr", last_gnt_addr, 32'h0);
        wait_pops(pops + 2, "wrap_stream");

        // Reset during WAIT; the late response must be ignored
        lat = 3;
        wait_new_gnt("pre_rst_gnt");
        initiate = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, imem_req}, 32'd0);
        check("mid_rst_addr", imem_addr, 32'd0);
        check("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
        check("mid_rst_pc", inst_pc, 32'd0);
        cyc(1);
        initiate = 1'b1;
        wait_new_gnt("post_rst_gnt");
        check("post_rst_addr", last_gnt_addr, 32'd0);
        wait_pops(pops + 2, "post_rst_stream");

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            inst_ready = ($urandom_range(0, 3) != 0);
            halt = ($urandom_range(0, 9) == 0);
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_pc = $urandom();
            if ($urandom_range(0, 19) == 0) gnt_delay = $urandom_range(0, 2);
            if ($urandom_range(0, 19) == 0) lat = $urandom_range(0, 2);
            cyc(1);
        end
        redirect_valid = 1'b0; halt = 1'b0; inst_ready = 1'b1;
        p0 = pops;
        cyc(40);
        check("final_progress", 32'(pops > p0), 32'd1);
`ifdef FETCH_PERF_COUNT_EN
        check("fetch_count", fetch_count, 32'(pops_rst));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage directly upstream of DataPath. It owns the PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake. Returned words are buffered in a small prefetch FIFO and presented to DataPath with a valid/ready handshake. Branch and jump redirects from DataPath flush the FIFO and discard any in-flight response.

Parameters:
ADDR_W, 32, PC and memory address width
DATA_W, 32, instruction word width
FIFO_DEPTH, 4, prefetch FIFO entries (power of 2, ≥2)
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
initiate  input  1  asynchronous active-low reset
imem_req  output  1  fetch request; held until imem_gnt
imem_addr  output  ADDR_W  fetch address, word aligned, stable while imem_req=1
imem_gnt  input  1  memory accepted request this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  DATA_W  read data
redirect_valid  input  1  one-cycle PC redirect from DataPath
redirect_pc  input  ADDR_W  redirect target; bits [1:0] ignored (forced 0)
halt  input  1  suppress new requests while high
inst_valid  output  1  FIFO head valid
inst_data  output  DATA_W  head instruction
inst_pc  output  ADDR_W  PC of head instruction
inst_ready  input  1  DataPath consumes head when inst_valid & inst_ready

Behaviour:
- Reset (initiate=0, async): pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, FIFO empty, inst_valid=0, inst_data=0, inst_pc=0, state=IDLE, discard flag=0.
- Rule: at most one outstanding request. A new request issues only if FIFO count < FIFO_DEPTH and halt=0, so FIFO overflow is impossible.
- FSM:
  - IDLE -> REQ when issue is allowed. imem_req=1 and imem_addr=pc take effect the next cycle.
  - REQ: imem_req=1, imem_addr held. On imem_gnt go to WAIT, or to DROP if the discard flag is set.
  - WAIT: on imem_rvalid push {pc, imem_rdata} and set pc=pc+4 (mod 2^ADDR_W). Then go to REQ if issue is still allowed, else IDLE. Back-to-back requests allowed.
  - DROP: on imem_rvalid discard data, clear the discard flag, go to IDLE.
- Latency:
  - gnt in cycle N; rvalid no earlier than N+1.
  - rvalid in cycle M gives inst_valid=1 in cycle M+1 if the FIFO was empty.
  - inst_valid = (count != 0); inst_data and inst_pc are the FIFO head outputs.
- Redirect (priority over all other events in the same cycle):
  - FIFO flushed; inst_valid=0 next cycle. A pop in the same cycle is still considered consumed.
  - pc=redirect_pc with bits [1:0] cleared.
  - In IDLE: issue the new PC next cycle.
  - In REQ: address stays held until gnt (handshake legality); set discard flag, then go to DROP after gnt.
  - In WAIT: go to DROP. If rvalid arrives in the same cycle, the data is dropped and the state goes to IDLE.
  - In DROP: pc updated, state stays DROP.
- Push and pop in the same cycle: count unchanged; order preserved.
- imem_rvalid in IDLE or REQ is ignored.
- halt: blocks only new issues. An outstanding request completes and pushes normally. FIFO contents remain poppable.
- Reset mid-operation: all state returns to reset values immediately; an in-flight response arriving after reset release is ignored (state IDLE).

Optional Feature:
FETCH_PERF_COUNT_EN
- Defined: adds outputs fetch_count[31:0] and stall_count[31:0], both reset to 0 and wrapping at 2^32.
  - fetch_count increments on each pop.
  - stall_count increments each cycle inst_valid=0 and halt=0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, halt=0, memory answers gnt the same cycle as req and rvalid 1 cycle later with data=addr^32'hA5A5A5A5, inst_ready=1 -> inst_pc sequence 0,4,8,C with matching data; no gaps once streaming begins.
- inst_ready=0 for 20 cycles -> exactly 4 entries buffered, imem_req stays 0 after the 4th push. Then ready=1 -> pops in order 0,4,8,C, and fetching resumes at 0x10.
- Redirect to 0x0000_0103 while in WAIT for 0x8 -> response for 0x8 dropped, FIFO empty, next imem_addr=0x0000_0100, first inst_pc=0x100.
- Redirect while imem_req=1 with gnt delayed 3 cycles -> imem_addr stays at the old value until gnt, its response is discarded, then a request for the redirect target issues.
- pc=32'hFFFF_FFFC fetched -> next imem_addr=0x0000_0000 (wrap).
- initiate pulsed low during WAIT -> outputs reset immediately; a late rvalid is ignored; fetch restarts at RESET_PC.
